shifter_operand_gen: RTL

Sequential operand generator that drives the barrel shifter. It accepts the ARM data-processing operand2 field (immediate or register form) and fetches Rm and, when needed, Rs through the single-port register file. It then emits one complete shifter operand packet: type, 5-bit offset, op_m, carry_in, and the special-case flags. It sits between decode and the shifter/ALU, resolving all ARM amount encodings (LSL #0, #32, >32, RRX, and register ROR multiples of 32) that the 5-bit shifter cannot express alone.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_amt_decode.sv | 67 ++++++
 rtl/shifter_operand_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the shifter operand generator: shift type codes,
// generator state encodings, packet field widths and the operand form tag.
package shift_pkg;
    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int TYPE_W   = 2;
    localparam int OP2_W    = 12;

    localparam logic [1:0] SRTYPE_LSL = 2'b00;
    localparam logic [1:0] SRTYPE_LSR = 2'b01;
    localparam logic [1:0] SRTYPE_ASR = 2'b10;
    localparam logic [1:0] SRTYPE_ROR = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RM   = 3'd1;
    localparam logic [2:0] ST_RS   = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    typedef enum logic [1:0] {
        FORM_IMM       = 2'd0,
        FORM_IMM_SHIFT = 2'd1,
        FORM_REG_SHIFT = 2'd2
    } form_e;
endpackage

// File: rtl/shift_amt_decode.sv
// Combinational resolution of ARM shift-amount encodings into the 5-bit
// shifter offset plus the bypass / force-zero special cases.
module shift_amt_decode
    import shift_pkg::*;
(
    input  form_e                 form,
    input  logic [TYPE_W-1:0]     s_type,
    input  logic [7:0]            amount,
    input  logic                  cflag,
    input  logic                  rm_msb,
    output logic [OFFSET_W-1:0]   offset,
    output logic                  bypass,
    output logic                  bypass_c,
    output logic                  force_zero
);
    always_comb begin
        offset     = '0;
        bypass     = 1'b0;
        bypass_c   = 1'b0;
        force_zero = 1'b0;
        case (form)
            FORM_IMM: begin
                // amount[3:0] is the rotate field; rotation is by twice its value
                if (amount[3:0] == 4'd0) begin
                    bypass   = 1'b1;
                    bypass_c = cflag;
                end else begin
                    offset = {amount[3:0], 1'b0};
                end
            end
            FORM_IMM_SHIFT: begin
                if (s_type == SRTYPE_LSL && amount[4:0] == 5'd0) begin
                    bypass   = 1'b1;
                    bypass_c = cflag;
                end else begin
                    offset = amount[4:0];
                end
            end
            FORM_REG_SHIFT: begin
                if (amount == 8'd0) begin
                    bypass   = 1'b1;
                    bypass_c = cflag;
                end else begin
                    case (s_type)
                        SRTYPE_LSL, SRTYPE_LSR: begin
                            if (amount > 8'd32) force_zero = 1'b1;
                            else                offset     = amount[4:0];
                        end
                        SRTYPE_ASR: begin
                            // offset 0 makes the shifter perform ASR #32 (sign fill)
                            if (amount < 8'd32) offset = amount[4:0];
                        end
                        default: begin
                            if (amount[4:0] == 5'd0) begin
                                bypass   = 1'b1;
                                bypass_c = rm_msb;
                            end else begin
                                offset = amount[4:0];
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/shifter_operand_gen.sv
// Sequential operand2 front end for the barrel shifter: fetches Rm/Rs and emits
// one shifter packet. Define SHOPGEN_PIPE_EN to accept a new request in OUT.
module shifter_operand_gen
    import shift_pkg::*;
#(
    parameter int RF_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_i,
    input  logic [OP2_W-1:0]     in_op2,
    input  logic                 in_cflag,
    output logic                 rf_re,
    output logic [3:0]           rf_addr,
    input  logic [DATA_W-1:0]    rf_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TYPE_W-1:0]    s_type,
    output logic [OFFSET_W-1:0]  offset,
    output logic [DATA_W-1:0]    op_m,
    output logic                 carry_in,
    output logic                 bypass,
    output logic                 bypass_c,
    output logic                 force_zero
);
    generate
        if (RF_LAT != 1) begin : g_rf_lat_unsupported
            $error("shifter_operand_gen: only RF_LAT=1 is supported");
        end
    endgenerate

    logic [2:0]          state_q, state_d;
    logic [OP2_W-1:0]    op2_q, op2_d;
    logic                cflag_q, cflag_d;
    logic [DATA_W-1:0]   rm_q, rm_d;

    logic [TYPE_W-1:0]   s_type_q, s_type_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0]   op_m_q, op_m_d;
    logic                carry_in_q, carry_in_d;
    logic                bypass_q, bypass_d;
    logic                bypass_c_q, bypass_c_d;
    logic                force_zero_q, force_zero_d;

    logic                accept;
    logic                in_cap;
    form_e               dec_form;
    logic [TYPE_W-1:0]   dec_type;
    logic [7:0]          dec_amount;
    logic                dec_cflag;
    logic [OFFSET_W-1:0] dec_offset;
    logic                dec_bypass, dec_bypass_c, dec_force_zero;

`ifdef SHOPGEN_PIPE_EN
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_OUT && out_ready);
`else
    assign in_ready = (state_q == ST_IDLE);
`endif
    assign accept    = in_valid && in_ready;
    assign in_cap    = (state_q == ST_CAP);
    assign out_valid = (state_q == ST_OUT);
    assign rf_re     = (state_q == ST_RM) || (state_q == ST_RS);
    assign rf_addr   = (state_q == ST_RM) ? op2_q[3:0] :
                       (state_q == ST_RS) ? op2_q[11:8] : 4'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = in_i ? ST_OUT : ST_RM;
            ST_RM:   state_d = op2_q[4] ? ST_RS : ST_CAP;
            ST_RS:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    if (accept) state_d = in_i ? ST_OUT : ST_RM;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op2_d   = accept ? in_op2 : op2_q;
        cflag_d = accept ? in_cflag : cflag_q;
        rm_d    = (state_q == ST_RS) ? rf_rdata : rm_q;
    end

    // The single decoder serves immediates at accept time and register forms in CAP.
    always_comb begin
        if (in_cap) begin
            dec_form   = op2_q[4] ? FORM_REG_SHIFT : FORM_IMM_SHIFT;
            dec_type   = op2_q[6:5];
            dec_amount = op2_q[4] ? rf_rdata[7:0] : {3'b000, op2_q[11:7]};
            dec_cflag  = cflag_q;
        end else begin
            dec_form   = FORM_IMM;
            dec_type   = SRTYPE_ROR;
            dec_amount = {4'b0000, in_op2[11:8]};
            dec_cflag  = in_cflag;
        end
    end

    shift_amt_decode u_decode (
        .form       (dec_form),
        .s_type     (dec_type),
        .amount     (dec_amount),
        .cflag      (dec_cflag),
        .rm_msb     (rm_q[31]),
        .offset     (dec_offset),
        .bypass     (dec_bypass),
        .bypass_c   (dec_bypass_c),
        .force_zero (dec_force_zero)
    );

    always_comb begin
        s_type_d     = s_type_q;
        offset_d     = offset_q;
        op_m_d       = op_m_q;
        carry_in_d   = carry_in_q;
        bypass_d     = bypass_q;
        bypass_c_d   = bypass_c_q;
        force_zero_d = force_zero_q;
        if (accept && in_i) begin
            s_type_d     = SRTYPE_ROR;
            offset_d     = dec_offset;
            op_m_d       = {24'd0, in_op2[7:0]};
            carry_in_d   = 1'b0;
            bypass_d     = dec_bypass;
            bypass_c_d   = dec_bypass_c;
            force_zero_d = dec_force_zero;
        end else if (in_cap) begin
            // Register shifts never need an RRX fill, so carry_in only follows C for immediate shifts
            s_type_d     = op2_q[6:5];
            offset_d     = dec_offset;
            op_m_d       = op2_q[4] ? rm_q : rf_rdata;
            carry_in_d   = op2_q[4] ? 1'b0 : cflag_q;
            bypass_d     = dec_bypass;
            bypass_c_d   = dec_bypass_c;
            force_zero_d = dec_force_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_type_q     <= '0;
            offset_q     <= '0;
            op_m_q       <= '0;
            carry_in_q   <= 1'b0;
            bypass_q     <= 1'b0;
            bypass_c_q   <= 1'b0;
            force_zero_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_type_q     <= s_type_d;
            offset_q     <= offset_d;
            op_m_q       <= op_m_d;
            carry_in_q   <= carry_in_d;
            bypass_q     <= bypass_d;
            bypass_c_q   <= bypass_c_d;
            force_zero_q <= force_zero_d;
        end
    end

    always_ff @(posedge clk) begin
        op2_q   <= op2_d;
        cflag_q <= cflag_d;
        rm_q    <= rm_d;
    end

    assign s_type     = s_type_q;
    assign offset     = offset_q;
    assign op_m       = op_m_q;
    assign carry_in   = carry_in_q;
    assign bypass     = bypass_q;
    assign bypass_c   = bypass_c_q;
    assign force_zero = force_zero_q;
endmodule
